// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Purpose:
//   Cleans up the four raw push buttons (right, up, down, left) for the lab5
//   control logic. Each channel is a 2-flop synchronizer followed by a
//   counter-based debouncer. Each channel yields a debounced level and a
//   single-cycle press pulse. The channels are identical and independent.
//
// Optional feature (compile-time macro):
//   BTN_AUTOREPEAT_EN - when defined, each channel also runs a small repeat
//   FSM. A held button emits a first repeat pulse REPEAT_DELAY cycles after
//   its press pulse, then one every REPEAT_PERIOD cycles. When undefined,
//   exactly one pulse is produced per debounced press and the REPEAT_*
//   parameters have no effect.
//
// Parameters:
//   DEB_CYCLES    - consecutive mismatching cycles before the level flips (>= 2)
//   REPEAT_DELAY  - hold time from the press pulse to the first repeat pulse
//   REPEAT_PERIOD - spacing between subsequent repeat pulses
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-low reset
//   BTNR/U/D/L in   raw asynchronous buttons
//   level      out  [3:0] debounced levels, bit order {L,D,U,R}
//   pulse      out  [3:0] registered one-cycle press/repeat pulses, same order
//   any_pulse  out  OR of pulse
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BTNR,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  output logic [3:0] level,
  output logic [3:0] pulse,
  output logic       any_pulse
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [3:0]    btn_raw_s;
  logic [3:0]    s1_q;
  logic [3:0]    s2_q;
  logic [3:0]    stable_q;
  logic [3:0]    stable_d;
  logic [3:0]    press_s;
  logic [3:0]    pulse_q;
  logic [3:0]    pulse_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  assign btn_raw_s = {BTNL, BTND, BTNU, BTNR};

  // Debouncer next state: count consecutive mismatches, flip on the last one
  always_comb begin
    stable_d = stable_q;
    press_s  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = {CW{1'b0}};
        // only a 0->1 flip is a press; releases are silent
        press_s[i]  = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1'b1);
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_e;

  rpt_state_e    state_q [4];
  rpt_state_e    state_d [4];
  logic [RW-1:0] rcnt_q  [4];
  logic [RW-1:0] rcnt_d  [4];
  logic [3:0]    repeat_s;

  // Repeat FSM next state; uses the post-edge stable value so a release
  // edge can never coincide with a repeat pulse
  always_comb begin
    repeat_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (press_s[i]) begin
            state_d[i] = ST_WAIT;
            rcnt_d[i]  = {RW{1'b0}};
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!stable_d[i]) begin
            state_d[i] = ST_IDLE;
            rcnt_d[i]  = {RW{1'b0}};
          end else if (rcnt_q[i] == DELAY_LAST) begin
            repeat_s[i] = 1'b1;
            rcnt_d[i]   = {RW{1'b0}};
            state_d[i]  = ST_RPT;
          end else begin
            rcnt_d[i] = rcnt_q[i] + RW'(1'b1);
          end
        end
        ST_RPT: begin
          if (!stable_d[i]) begin
            state_d[i] = ST_IDLE;
            rcnt_d[i]  = {RW{1'b0}};
          end else if (rcnt_q[i] == PERIOD_LAST) begin
            repeat_s[i] = 1'b1;
            rcnt_d[i]   = {RW{1'b0}};
          end else begin
            rcnt_d[i] = rcnt_q[i] + RW'(1'b1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          rcnt_d[i]  = {RW{1'b0}};
        end
      endcase
    end
  end

  // Repeat FSM state and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_IDLE;
        rcnt_q[i]  <= {RW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  // Pulse source: press or repeat
  always_comb begin
    pulse_d = press_s | repeat_s;
  end
`else
  // Repeat timing has no meaning without the repeat FSM; fold the parameters
  // into a deliberately unused signal so they remain part of the interface.
  logic [31:0] unused_rpt_cfg_s;
  assign unused_rpt_cfg_s = 32'(REPEAT_DELAY) ^ 32'(REPEAT_PERIOD);

  // Pulse source: press only
  always_comb begin
    pulse_d = press_s;
  end
`endif

  // Synchronizer, debouncer and pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q     <= 4'b0000;
      s2_q     <= 4'b0000;
      stable_q <= 4'b0000;
      pulse_q  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      s1_q     <= btn_raw_s;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level     = stable_q;
  assign pulse     = pulse_q;
  assign any_pulse = |pulse_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Self-checking bench for btn_conditioner with DEB_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. A behavioural model (mismatch run lengths and
// time-since-press arithmetic) is compared against the DUT on every cycle.
// It is combined with a phase table, hand-written latency sequences and
// randomized button activity. Honours BTN_AUTOREPEAT_EN for its expectations.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = DEB + 2;

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD60_PULSES = 6;
`else
  localparam int HOLD60_PULSES = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] level;
  logic [3:0] pulse;
  logic       any_pulse;

  int checks;
  int errors;

  btn_conditioner #(
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .BTNR     (btn[0]),
    .BTNU     (btn[1]),
    .BTND     (btn[2]),
    .BTNL     (btn[3]),
    .level    (level),
    .pulse    (pulse),
    .any_pulse(any_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0] m_s1, m_s2, m_stab, m_level, m_pulse;
  int         m_run   [4];
  int         m_since [4];

  task automatic model_reset();
    m_s1 = 4'b0; m_s2 = 4'b0; m_stab = 4'b0; m_level = 4'b0; m_pulse = 4'b0;
    for (int i = 0; i < 4; i++) begin
      m_run[i]   = 0;
      m_since[i] = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_edge();
    logic [3:0] old;
    m_pulse = 4'b0;
    if (!rst) begin
      model_reset();
    end else begin
      old = m_stab;
      for (int i = 0; i < 4; i++) begin
        // level flips once the synchronized input has disagreed for DEB edges in a row
        if (m_s2[i] != old[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_stab[i] = m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        if (!old[i] && m_stab[i]) begin
          m_pulse[i] = 1'b1;
          m_since[i] = 0;
        end else if (old[i] && m_stab[i]) begin
          m_since[i] = m_since[i] + 1;
`ifdef BTN_AUTOREPEAT_EN
          if (m_since[i] == RD || (m_since[i] > RD && (m_since[i] - RD) % RP == 0))
            m_pulse[i] = 1'b1;
`endif
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
    m_level = m_stab;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // One clock: step the model at the edge, compare #1 later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_level", {28'b0, level}, {28'b0, m_level});
    chk("model_pulse", {28'b0, pulse}, {28'b0, m_pulse});
    chk("model_any_pulse", {31'b0, any_pulse}, {31'b0, |m_pulse});
  endtask

  // Inputs already applied; check exact press (rising) or release timing.
  task automatic watch(input logic [3:0] m, input int n, input bit rising, input string nm);
    logic [3:0] el, ep;
    for (int j = 1; j <= n; j++) begin
      tick();
      if (rising) begin
        el = (j >= LAT) ? m : 4'b0;
        ep = (j == LAT) ? m : 4'b0;
      end else begin
        el = (j >= LAT) ? 4'b0 : m;
        ep = 4'b0;
      end
      chk({nm, "_level"}, {28'b0, level}, {28'b0, el});
      chk({nm, "_pulse"}, {28'b0, pulse}, {28'b0, ep});
    end
  endtask

  typedef struct {
    logic [3:0] b;
    int         cycles;
    logic [3:0] exp_level;
    int         exp_npulse;
  } phase_t;

  phase_t tbl [10];
  int     hold_left [4];

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    btn    = 4'hF;
    model_reset();

    // 1. reset held with all buttons pressed, then fresh press after release
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("rst_level", {28'b0, level}, 32'h0);
      chk("rst_pulse", {28'b0, pulse}, 32'h0);
      chk("rst_any",   {31'b0, any_pulse}, 32'h0);
    end
    rst = 1'b1;
    watch(4'hF, LAT + 1, 1'b1, "post_rst_press");
    btn = 4'h0;
    watch(4'hF, LAT + 1, 1'b0, "all_release");

    // 2-5. phase table: glitches, single press, dual press, long hold
    tbl[0] = '{4'b0001, 3,  4'b0000, 0};
    tbl[1] = '{4'b0000, 1,  4'b0000, 0};
    tbl[2] = '{4'b0001, 3,  4'b0000, 0};
    tbl[3] = '{4'b0000, 8,  4'b0000, 0};
    tbl[4] = '{4'b0010, 12, 4'b0010, 1};
    tbl[5] = '{4'b0000, 8,  4'b0000, 0};
    tbl[6] = '{4'b1100, 8,  4'b1100, 2};
    tbl[7] = '{4'b0000, 8,  4'b0000, 0};
    tbl[8] = '{4'b0001, 60, 4'b0001, HOLD60_PULSES};
    tbl[9] = '{4'b0000, 10, 4'b0000, 0};
    for (int p = 0; p < 10; p++) begin
      int np;
      np  = 0;
      btn = tbl[p].b;
      for (int j = 0; j < tbl[p].cycles; j++) begin
        tick();
        np += $countones(pulse);
      end
      chk($sformatf("phase%0d_level", p), {28'b0, level}, {28'b0, tbl[p].exp_level});
      chk($sformatf("phase%0d_npulse", p), np, tbl[p].exp_npulse);
    end

    // 3. exact press/release timing on BTNU
    btn = 4'b0010;
    watch(4'b0010, 12, 1'b1, "up_press");
    btn = 4'b0000;
    watch(4'b0010, LAT + 2, 1'b0, "up_release");

    // 6. one-cycle reset while held (deep in repeat when enabled)
    btn = 4'b0001;
    for (int j = 0; j < 30; j++) tick();
    rst = 1'b0;
    tick();
    chk("midhold_rst_level", {28'b0, level}, 32'h0);
    chk("midhold_rst_pulse", {28'b0, pulse}, 32'h0);
    chk("midhold_rst_any",   {31'b0, any_pulse}, 32'h0);
    rst = 1'b1;
    watch(4'b0001, LAT + 1, 1'b1, "rehold_press");
    btn = 4'b0000;
    for (int j = 0; j < 10; j++) tick();

    // randomized activity against the model
    for (int i = 0; i < 4; i++) hold_left[i] = 0;
    for (int j = 0; j < 3000; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold_left[i] == 0) begin
          btn[i] = ~btn[i];
          hold_left[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 60))
                                                    : int'($urandom_range(1, 10));
        end else begin
          hold_left[i]--;
        end
      end
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1;
    btn = 4'b0000;
    for (int j = 0; j < 12; j++) tick();
    chk("final_level", {28'b0, level}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
